// File: rtl/logic_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with zero/negative/all-ones/error flags.
// Valid/ready on both sides; empty stages always accept, so bubbles collapse.
module logic_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [2:0]                   op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out,
  output logic                         zr,
  output logic                         ng,
  output logic                         all1,
  output logic                         err,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OCC_W = $clog2(STAGES + 1);

  // Handshake: a side transfers on a rising edge where its valid and ready are
  // both 1; in_ready depends only on stage state and out_ready, never in_valid.

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zr;
    logic             ng;
    logic             all1;
    logic             err;
  } bundle_t;

  logic [WIDTH-1:0] w_res;
  bundle_t          w_in_bundle;
  logic [STAGES-1:0] w_adv;
  logic [OCC_W-1:0] w_occ;

  logic [STAGES-1:0] r_v;
  bundle_t           r_bundle [STAGES];

  always_comb begin
    w_res = '0;
    case (op)
      3'b000:  w_res = a & b;
      3'b001:  w_res = a | b;
      3'b010:  w_res = a ^ b;
      3'b011:  w_res = ~(a & b);
      3'b100:  w_res = ~(a | b);
      3'b101:  w_res = ~(a ^ b);
      3'b110:  w_res = ~a;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_in_bundle      = '0;
    w_in_bundle.res  = w_res;
    w_in_bundle.zr   = (w_res == '0);
    w_in_bundle.ng   = w_res[WIDTH-1];
    w_in_bundle.all1 = &w_res;
    w_in_bundle.err  = (op == 3'b111);
  end

  // Stage i moves iff the consumer takes the output or some stage at or after i is empty.
  always_comb begin
    logic v_tmp;
    w_adv = '0;
    for (int i = 0; i < STAGES; i++) begin
      v_tmp = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!r_v[j]) v_tmp = 1'b1;
      end
      w_adv[i] = v_tmp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v[0]      <= 1'b0;
      r_bundle[0] <= '0;
    end else if (w_adv[0]) begin
      r_v[0] <= in_valid;
      if (in_valid) r_bundle[0] <= w_in_bundle;
    end
  end

  // Bundles only load behind a valid item so idle output data stays stable.
  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[g]      <= 1'b0;
        r_bundle[g] <= '0;
      end else if (w_adv[g]) begin
        r_v[g] <= r_v[g-1];
        if (r_v[g-1]) r_bundle[g] <= r_bundle[g-1];
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ = w_occ + OCC_W'(r_v[i]);
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[STAGES-1];
  assign out       = r_bundle[STAGES-1].res;
  assign zr        = r_bundle[STAGES-1].zr;
  assign ng        = r_bundle[STAGES-1].ng;
  assign all1      = r_bundle[STAGES-1].all1;
  assign err       = r_bundle[STAGES-1].err;
  assign occupancy = w_occ;

endmodule

// File: tb/tb_logic_pipe.sv
// Bench for logic_pipe: STAGES = 1, 2 and 4 instances share one stimulus stream,
// each checked every cycle against a queue-based model of items in flight.
module tb_logic_pipe;

  typedef struct {
    logic [19:0] bnd;
    int          acc_edge;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  op = '0;

  logic [2:0]  ir, ov, zr_o, ng_o, a1_o, er_o;
  logic [15:0] out_o [3];
  logic [0:0]  occ0;
  logic [1:0]  occ1;
  logic [2:0]  occ2;
  int          occ_v [3];

  item_t exp_q0[$], exp_q1[$], exp_q2[$];
  item_t ret1[$];
  int    e_cnt = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  logic_pipe #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .op(op), .out_valid(ov[0]), .out_ready(out_ready),
    .out(out_o[0]), .zr(zr_o[0]), .ng(ng_o[0]), .all1(a1_o[0]),
    .err(er_o[0]), .occupancy(occ0));

  logic_pipe #(.WIDTH(16), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .op(op), .out_valid(ov[1]), .out_ready(out_ready),
    .out(out_o[1]), .zr(zr_o[1]), .ng(ng_o[1]), .all1(a1_o[1]),
    .err(er_o[1]), .occupancy(occ1));

  logic_pipe #(.WIDTH(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .op(op), .out_valid(ov[2]), .out_ready(out_ready),
    .out(out_o[2]), .zr(zr_o[2]), .ng(ng_o[2]), .all1(a1_o[2]),
    .err(er_o[2]), .occupancy(occ2));

  always_comb begin
    occ_v[0] = int'(occ0);
    occ_v[1] = int'(occ1);
    occ_v[2] = int'(occ2);
  end

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic [2:0] mop);
    logic [15:0] r;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd2: r = ma ^ mb;
      3'd3: r = ~(ma & mb);
      3'd4: r = ~(ma | mb);
      3'd5: r = ~(ma ^ mb);
      3'd6: r = ~ma;
      default: r = 16'h0000;
    endcase
    return {r, r == 16'h0000, r[15], r == 16'hFFFF, mop == 3'd7};
  endfunction

  function automatic int stg(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic int qsz(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic item_t qfront(input int k);
    case (k)
      0: return exp_q0[0];
      1: return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  function automatic void qpop(input int k);
    case (k)
      0: exp_q0.delete(0);
      1: exp_q1.delete(0);
      default: exp_q2.delete(0);
    endcase
  endfunction

  function automatic void qpush(input int k, input item_t it);
    case (k)
      0: exp_q0.push_back(it);
      1: exp_q1.push_back(it);
      default: exp_q2.push_back(it);
    endcase
  endfunction

  // The oldest item never waits on anything ahead, so it reaches the output
  // STAGES-1 edges after its accept edge.
  function automatic logic m_valid(input int k);
    if (qsz(k) == 0) return 1'b0;
    return (e_cnt - qfront(k).acc_edge) >= stg(k) - 1;
  endfunction

  function automatic logic m_ready(input int k);
    return (qsz(k) < stg(k)) || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        item_t it;
        logic  acc, ret;
        acc = in_valid && m_ready(k);
        ret = m_valid(k) && out_ready;
        if (ret) qpop(k);
        if (acc) begin
          it.bnd      = model(a, b, op);
          it.acc_edge = e_cnt + 1;
          qpush(k, it);
        end
      end
      e_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n) begin
        chk($sformatf("s%0d_in_ready", stg(k)), 32'(ir[k]), 32'(m_ready(k)));
        chk($sformatf("s%0d_out_valid", stg(k)), 32'(ov[k]), 32'(m_valid(k)));
        chk($sformatf("s%0d_occupancy", stg(k)), occ_v[k], qsz(k));
        if (ov[k] && m_valid(k))
          chk($sformatf("s%0d_payload", stg(k)),
              32'({out_o[k], zr_o[k], ng_o[k], a1_o[k], er_o[k]}), 32'(qfront(k).bnd));
      end else begin
        chk($sformatf("s%0d_rst_valid", stg(k)), 32'(ov[k]), 0);
        chk($sformatf("s%0d_rst_occ", stg(k)), occ_v[k], 0);
      end
    end
    if (rst_n && ov[1] && out_ready) begin
      item_t r;
      r.bnd      = {out_o[1], zr_o[1], ng_o[1], a1_o[1], er_o[1]};
      r.acc_edge = e_cnt;
      ret1.push_back(r);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one item until the STAGES=2 instance takes it.
  task automatic send1(input logic [15:0] ta, input logic [15:0] tb_v, input logic [2:0] top);
    bit done = 1'b0;
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      if (ir[1]) done = 1'b1;
      step();
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_ret(input int n);
    for (int c = 0; c < 100 && ret1.size() < n; c++) step();
    chk("ret_count", ret1.size(), n);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_s%0d_valid", tag, stg(k)), 32'(ov[k]), 0);
      chk($sformatf("%s_s%0d_out", tag, stg(k)), 32'(out_o[k]), 0);
      chk($sformatf("%s_s%0d_flags", tag, stg(k)),
          32'({zr_o[k], ng_o[k], a1_o[k], er_o[k]}), 0);
      chk($sformatf("%s_s%0d_occ", tag, stg(k)), occ_v[k], 0);
      chk($sformatf("%s_s%0d_ready", tag, stg(k)), 32'(ir[k]), 1);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 3))
      0: return 16'h0000;
      1: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [19:0] exp_tab [4];

    // Reset with random inputs, observed before any clock edge.
    a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
    in_valid = 1'b1; out_ready = 1'($urandom);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Model pins.
    chk("pin_and",  32'(model(16'hFF00, 16'h0F0F, 3'd0)), 32'({16'h0F00, 4'b0000}));
    chk("pin_nor",  32'(model(16'h0000, 16'h0000, 3'd4)), 32'({16'hFFFF, 4'b0110}));
    chk("pin_rsv",  32'(model(16'hFFFF, 16'hFFFF, 3'd7)), 32'({16'h0000, 4'b1001}));
    chk("pin_not",  32'(model(16'h1234, 16'hABCD, 3'd6)), 32'({16'hEDCB, 4'b0100}));

    // AND path latency on STAGES=2.
    send1(16'hFF00, 16'h0F0F, 3'd0);
    chk("and_not_yet", 32'(ov[1]), 0);
    step();
    chk("and_valid", 32'(ov[1]), 1);
    chk("and_out", 32'({out_o[1], zr_o[1], ng_o[1], a1_o[1], er_o[1]}), 32'({16'h0F00, 4'b0000}));
    repeat (3) step();

    // Back-to-back flag and op sweep.
    ret1.delete();
    send1(16'hFFFF, 16'hFFFF, 3'd3);
    send1(16'h0000, 16'h0000, 3'd4);
    send1(16'h8001, 16'h0001, 3'd2);
    send1(16'h1234, 16'h0000, 3'd6);
    wait_ret(4);
    exp_tab = '{{16'h0000, 4'b1000}, {16'hFFFF, 4'b0110}, {16'h8000, 4'b0100}, {16'hEDCB, 4'b0100}};
    for (int i = 0; i < 4 && i < ret1.size(); i++) begin
      chk($sformatf("sweep_%0d", i), 32'(ret1[i].bnd), 32'(exp_tab[i]));
      if (i > 0) chk($sformatf("sweep_rate_%0d", i), ret1[i].acc_edge - ret1[i-1].acc_edge, 1);
    end
    repeat (4) step();

    // Backpressure: only two fit in STAGES=2.
    ret1.delete();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a = 16'(i); b = 16'h0000; op = 3'd6; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("bp_occ", occ_v[1], 2);
    chk("bp_ready", 32'(ir[1]), 0);
    out_ready = 1'b1;
    send1(16'h0003, 16'h0000, 3'd6);
    send1(16'h0004, 16'h0000, 3'd6);
    wait_ret(4);
    exp_tab = '{{16'hFFFE, 4'b0100}, {16'hFFFD, 4'b0100}, {16'hFFFC, 4'b0100}, {16'hFFFB, 4'b0100}};
    for (int i = 0; i < 4 && i < ret1.size(); i++)
      chk($sformatf("bp_order_%0d", i), 32'(ret1[i].bnd), 32'(exp_tab[i]));
    repeat (6) step();

    // Reserved op then a normal op.
    ret1.delete();
    send1(16'hFFFF, 16'hFFFF, 3'd7);
    send1(16'hFFFF, 16'hFFFF, 3'd0);
    wait_ret(2);
    if (ret1.size() >= 2) begin
      chk("rsv_item", 32'(ret1[0].bnd), 32'({16'h0000, 4'b1001}));
      chk("rsv_next", 32'(ret1[1].bnd), 32'({16'hFFFF, 4'b0110}));
    end
    repeat (6) step();

    // Mid-stream reset with two items in flight.
    out_ready = 1'b0;
    send1(16'h1111, 16'h0101, 3'd0);
    send1(16'h2222, 16'h0202, 3'd1);
    chk("mid_occ_before", occ_v[1], 2);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    ret1.delete();
    send1(16'h00FF, 16'h0FF0, 3'd0);
    repeat (8) step();
    chk("mid_single", ret1.size(), 1);
    if (ret1.size() >= 1) chk("mid_value", 32'(ret1[0].bnd), 32'({16'h00F0, 4'b0000}));

    // Randomized traffic with phases of heavy and light backpressure.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (cyc % 300 < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      a  = pick();
      b  = pick();
      op = 3'($urandom_range(0, 7));
      if (cyc % 500 == 250) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, pipelined bitwise logic unit generalising the team's single-bit AND gate to WIDTH-bit operands and seven selectable operations. It accepts one operation per cycle on a valid/ready input, carries the result through STAGES register stages with full backpressure, and presents the result with zero, negative and all-ones flags. It sits between the operand sources and the datapath result bus, and is the building block for the future ALU logic path.

## Interface
- WIDTH, 16, operand and result width in bits; legal values are 1 or more.
- STAGES, 2, number of pipeline register stages; legal values are 1 to 4.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  the operand triple {a, b, op} is presented.
- in_ready  output  1  the block accepts the triple this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation select.
- out_valid  output  1  the last stage holds a result.
- out_ready  input  1  the consumer takes the result this cycle.
- out  output  WIDTH  result.
- zr  output  1  result equals 0.
- ng  output  1  result MSB, out[WIDTH-1].
- all1  output  1  every result bit is 1.
- err  output  1  the op code was reserved.
- occupancy  output  $clog2(STAGES+1)  number of valid stages.

## Operation
- Op encoding:
  - 000 AND, 001 OR, 010 XOR.
  - 011 NAND, 100 NOR, 101 XNOR.
  - 110 NOT a (b is ignored).
  - 111 reserved: out = 0, err = 1.
- All ops are bitwise per bit.
- The result, zr, ng, all1 and err are computed combinationally from the inputs and captured into stage 1.
- Later stages only move the captured bundle. No flag is recomputed downstream.
- Each stage i holds a valid bit v[i] and a bundle {out, zr, ng, all1, err}.
- Stage advance rule:
  - The last stage advances when out_ready is 1 or v[last] is 0.
  - Stage i advances when v[i] is 0 or stage i+1 advances.
  - A stage that advances loads its predecessor's bundle and valid bit.
  - Stage 1's predecessor is the input, with valid bit = in_valid.
- in_ready = stage-1 advance condition. Input transfer = in_valid and in_ready.
- Bubbles collapse: an empty stage always accepts, even while the stages downstream of it are stalled.
- A stalled stage holds its bundle unchanged. No item is dropped, duplicated or reordered.
- out_valid = v[last]. out and the flags drive the last-stage bundle directly.
- occupancy = number of set v[i]. It ranges from 0 to STAGES.
- in_ready is not allowed to combinationally depend on in_valid. It may depend on out_ready.

## Timing
- Reset, while rst_n is low and taking effect immediately without a clock edge:
  - all v[i] = 0 and all bundle registers = 0;
  - out = 0, zr = 0, ng = 0, all1 = 0, err = 0;
  - out_valid = 0, occupancy = 0, in_ready = 1.
- Latency: an item accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, provided there is no stall. With STAGES = 1 it is valid directly after its accept edge.
- Throughput: one item per cycle while out_ready is held at 1.
- Full pipeline with out_ready = 0: in_ready = 0 and occupancy = STAGES.
- Full pipeline with out_ready = 1: in_ready = 1. An accept and a retire in the same cycle leave occupancy unchanged.
- Simultaneous accept and retire with a non-full pipeline: occupancy changes by 0.
- Reset asserted mid-stream: all in-flight items are discarded asynchronously. The first out_valid after reset release belongs to an item accepted after the release.
- Reset deassertion is synchronised by the integration. The block needs no internal synchroniser.
- While out_valid = 0, the output data is don't-care to consumers but is held stable.

## Test plan
Default configuration for all scenarios: WIDTH = 16, STAGES = 2.
- Reset: rst_n = 0 with random inputs -> out_valid = 0, out = 16'h0000, all flags 0, occupancy = 0, in_ready = 1, with no clock edge needed.
- AND path: a = FF00, b = 0F0F, op = 000 accepted at edge N -> after edge N+1, out_valid = 1, out = 0F00, zr = 0, ng = 0, all1 = 0.
- Flag and op sweep, run back-to-back with out_ready = 1:
  - NAND with a = b = FFFF -> 0000, zr = 1.
  - NOR with a = b = 0000 -> FFFF, ng = 1, all1 = 1.
  - XOR with a = 8001, b = 0001 -> 8000, ng = 1.
  - NOT a with a = 1234 -> EDCB.
  - Required: one result per cycle, in order.
- Backpressure: out_ready = 0 and in_valid = 1 for 4 cycles with items 0001, 0002, 0003, 0004 (op = 110 on a) -> only 2 are accepted, then in_ready = 0 and occupancy = 2. After out_ready = 1, results FFFE, FFFD, then FFFC, FFFB arrive with none lost or duplicated.
- Reserved op: op = 111 with a = b = FFFF -> out = 0000, err = 1, zr = 1. The next item with op = 000 returns err = 0.
- Mid-stream reset: 2 items in flight, rst_n pulsed low for half a cycle -> out_valid falls immediately and occupancy = 0. After release, a single new item appears with no stale results. Repeat the pipeline scenarios with STAGES = 1 and STAGES = 4.
